// File: rtl/pic_bus_pkg.sv
// Shared definitions for the PIC host bus master: top-level sequencer states,
// strobe-cycle phases and types, the non-specific EOI command word and the
// ICW1 bit positions that decide whether ICW3 / ICW4 are sent.
package pic_bus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_WR,
    ST_INIT_GAP,
    ST_CMD,
    ST_ACK1,
    ST_ACK_GAP,
    ST_ACK2,
    ST_EOI_GAP,
    ST_EOI_WR
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_PULSE,
    PH_HOLD
  } phase_e;

  typedef enum logic [1:0] {
    CYC_WR,
    CYC_RD,
    CYC_INTA
  } cyc_type_e;

  localparam logic [7:0]  EOI_NONSPEC = 8'h20;
  localparam int unsigned IC4         = 0;
  localparam int unsigned SNGL        = 1;

endpackage

// File: rtl/pic_bus_cycle.sv
// Runs one SETUP/PULSE/HOLD strobe cycle on the PIC bus.
// Ports: clk, rst_n (sync, active low); start/ctype/a0_in/wdata launch a cycle
// from idle; din is the bus input. Outputs cs/rd/wr/inta/bus_a0/d_out/d_oe are
// registered bus pins, last flags the final HOLD cycle (combinational),
// rdata holds the byte sampled at the end of the PULSE phase (RD/INTA only).
module pic_bus_cycle
  import pic_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  cyc_type_e  ctype,
  input  logic       a0_in,
  input  logic [7:0] wdata,
  input  logic [7:0] din,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic       inta,
  output logic       bus_a0,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       last,
  output logic [7:0] rdata
);

  phase_e    phase;
  cyc_type_e type_q;
  logic [7:0] cnt;

  assign last = (phase == PH_HOLD) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase  <= PH_IDLE;
      type_q <= CYC_WR;
      cnt    <= '0;
      cs     <= 1'b1;
      rd     <= 1'b1;
      wr     <= 1'b1;
      inta   <= 1'b1;
      bus_a0 <= 1'b0;
      d_out  <= '0;
      d_oe   <= 1'b0;
      rdata  <= '0;
    end else begin
      case (phase)
        PH_IDLE: begin
          if (start) begin
            phase  <= PH_SETUP;
            cnt    <= 8'(SETUP_CYC - 1);
            type_q <= ctype;
            cs     <= (ctype == CYC_INTA);
            bus_a0 <= (ctype == CYC_INTA) ? 1'b0 : a0_in;
            d_out  <= (ctype == CYC_WR) ? wdata : 8'h00;
            d_oe   <= (ctype == CYC_WR);
          end
        end
        PH_SETUP: begin
          if (cnt == '0) begin
            phase <= PH_PULSE;
            cnt   <= 8'(PULSE_CYC - 1);
            wr    <= (type_q != CYC_WR);
            rd    <= (type_q != CYC_RD);
            inta  <= (type_q != CYC_INTA);
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        PH_PULSE: begin
          if (cnt == '0) begin
            phase <= PH_HOLD;
            cnt   <= 8'(HOLD_CYC - 1);
            wr    <= 1'b1;
            rd    <= 1'b1;
            inta  <= 1'b1;
            if (type_q != CYC_WR) rdata <= din;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        PH_HOLD: begin
          if (cnt == '0) begin
            phase  <= PH_IDLE;
            cs     <= 1'b1;
            bus_a0 <= 1'b0;
            d_out  <= '0;
            d_oe   <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pic_host_bus_master.sv
// CPU-side bus master for a PIC: sends the ICW/OCW1 init queue, runs host
// command reads/writes and answers int_req with a two-pulse INTA acknowledge,
// optionally followed by a non-specific EOI write.
// Ports: clk, rst_n (sync, active low); init_start + icw1..ocw1 init words;
// auto_eoi; cmd_req/cmd_rd/cmd_a0/cmd_data -> cmd_ack/cmd_rdata; int_req
// (asynchronous INT pin) -> vec_valid/vec; busy; bus pins cs/rd/wr/inta/a0,
// d_out/d_oe, d_in.
module pic_host_bus_master
  import pic_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic [7:0] ocw1,
  input  logic       auto_eoi,
  input  logic       cmd_req,
  input  logic       cmd_rd,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  output logic       cmd_ack,
  output logic [7:0] cmd_rdata,
  input  logic       int_req,
  output logic       vec_valid,
  output logic [7:0] vec,
  output logic       busy,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic       inta,
  output logic       a0,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in
);

  state_e     state;
  logic       int_meta, int_s;
  logic       eoi_pend, cmd_is_rd;
  // Pending words after ICW1: [0]=ICW2 [1]=ICW3 [2]=ICW4 [3]=OCW1, all A0=1.
  logic [3:0] init_pend;
  logic [7:0] init_word [4];
  logic [1:0] head_idx;

  logic       cyc_start, cyc_a0, cyc_last;
  cyc_type_e  cyc_type;
  logic [7:0] cyc_wdata, cyc_rdata;

  always_comb begin
    head_idx = '0;
    for (int unsigned i = 4; i > 0; i--)
      if (init_pend[i-1]) head_idx = 2'(i - 1);
  end

  // Launch decode runs on the same edge as the FSM, so a cycle's SETUP
  // begins the cycle after the decision (no extra registered start).
  always_comb begin
    cyc_start = 1'b0;
    cyc_type  = CYC_WR;
    cyc_a0    = 1'b0;
    cyc_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (init_start) begin
          cyc_start = 1'b1;
          cyc_wdata = icw1;
        end else if (int_s) begin
          cyc_start = 1'b1;
          cyc_type  = CYC_INTA;
        end else if (cmd_req) begin
          cyc_start = 1'b1;
          cyc_type  = cmd_rd ? CYC_RD : CYC_WR;
          cyc_a0    = cmd_a0;
          cyc_wdata = cmd_data;
        end
      end
      ST_INIT_GAP: begin
        cyc_start = 1'b1;
        cyc_a0    = 1'b1;
        cyc_wdata = init_word[head_idx];
      end
      ST_ACK_GAP: begin
        cyc_start = 1'b1;
        cyc_type  = CYC_INTA;
      end
      ST_EOI_GAP: begin
        cyc_start = 1'b1;
        cyc_wdata = EOI_NONSPEC;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      int_meta  <= 1'b0;
      int_s     <= 1'b0;
      eoi_pend  <= 1'b0;
      cmd_is_rd <= 1'b0;
      init_pend <= '0;
      for (int unsigned i = 0; i < 4; i++) init_word[i] <= '0;
      cmd_ack   <= 1'b0;
      cmd_rdata <= '0;
      vec_valid <= 1'b0;
      vec       <= '0;
    end else begin
      int_meta  <= int_req;
      int_s     <= int_meta;
      cmd_ack   <= 1'b0;
      vec_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (init_start) begin
            state        <= ST_INIT_WR;
            busy         <= 1'b1;
            init_word[0] <= icw2;
            init_word[1] <= icw3;
            init_word[2] <= icw4;
            init_word[3] <= ocw1;
            init_pend    <= {1'b1, icw1[IC4], ~icw1[SNGL], 1'b1};
          end else if (int_s) begin
            state    <= ST_ACK1;
            busy     <= 1'b1;
            eoi_pend <= auto_eoi;
          end else if (cmd_req) begin
            state     <= ST_CMD;
            busy      <= 1'b1;
            cmd_is_rd <= cmd_rd;
          end
        end
        ST_INIT_WR: begin
          if (cyc_last) begin
            if (init_pend == '0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_INIT_GAP;
            end
          end
        end
        ST_INIT_GAP: begin
          init_pend[head_idx] <= 1'b0;
          state               <= ST_INIT_WR;
        end
        ST_CMD: begin
          if (cyc_last) begin
            cmd_ack <= 1'b1;
            if (cmd_is_rd) cmd_rdata <= cyc_rdata;
            state   <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        ST_ACK1:    if (cyc_last) state <= ST_ACK_GAP;
        ST_ACK_GAP: state <= ST_ACK2;
        ST_ACK2: begin
          if (cyc_last) begin
            vec       <= cyc_rdata;
            vec_valid <= 1'b1;
            if (eoi_pend) begin
              state <= ST_EOI_GAP;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        ST_EOI_GAP: state <= ST_EOI_WR;
        ST_EOI_WR: begin
          if (cyc_last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  pic_bus_cycle #(
    .SETUP_CYC(SETUP_CYC),
    .PULSE_CYC(PULSE_CYC),
    .HOLD_CYC (HOLD_CYC)
  ) u_cycle (
    .clk   (clk),
    .rst_n (rst_n),
    .start (cyc_start),
    .ctype (cyc_type),
    .a0_in (cyc_a0),
    .wdata (cyc_wdata),
    .din   (d_in),
    .cs    (cs),
    .rd    (rd),
    .wr    (wr),
    .inta  (inta),
    .bus_a0(a0),
    .d_out (d_out),
    .d_oe  (d_oe),
    .last  (cyc_last),
    .rdata (cyc_rdata)
  );

endmodule

// File: tb/tb_pic_host_bus_master.sv
// Directed bench for pic_host_bus_master with SETUP/PULSE/HOLD = 1/2/1.
module tb_pic_host_bus_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init_start = 1'b0;
  logic [7:0] icw1 = '0, icw2 = '0, icw3 = '0, icw4 = '0, ocw1 = '0;
  logic       auto_eoi = 1'b0;
  logic       cmd_req = 1'b0, cmd_rd = 1'b0, cmd_a0 = 1'b0;
  logic [7:0] cmd_data = '0;
  logic       cmd_ack;
  logic [7:0] cmd_rdata;
  logic       int_req = 1'b0;
  logic       vec_valid;
  logic [7:0] vec;
  logic       busy, cs, rd, wr, inta, a0, d_oe;
  logic [7:0] d_out;
  logic [7:0] d_in = 8'hA5;

  pic_host_bus_master #(.SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .ocw1(ocw1),
    .auto_eoi(auto_eoi), .cmd_req(cmd_req), .cmd_rd(cmd_rd), .cmd_a0(cmd_a0),
    .cmd_data(cmd_data), .cmd_ack(cmd_ack), .cmd_rdata(cmd_rdata),
    .int_req(int_req), .vec_valid(vec_valid), .vec(vec), .busy(busy),
    .cs(cs), .rd(rd), .wr(wr), .inta(inta), .a0(a0), .d_out(d_out),
    .d_oe(d_oe), .d_in(d_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bus monitor / bus model, sampling on the falling edge.
  int         cyc = 0;
  int         wr_n = 0, wr_low_n = 0, doe_n = 0, inta_n = 0, cs_bad_n = 0;
  int         rd_n = 0, rd_bad_n = 0, vv_n = 0, ack_n = 0;
  logic       wr_log_a0 [256];
  logic [7:0] wr_log_d  [256];
  int         wr_log_c  [256];
  int         inta_log_c [256];
  logic       wr_q = 1'b1, rd_q = 1'b1, inta_q = 1'b1;
  logic [7:0] bus_rdata = 8'h00, bus_vec = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!wr && wr_q && wr_n < 256) begin
        wr_log_a0[wr_n] = a0;
        wr_log_d[wr_n]  = d_out;
        wr_log_c[wr_n]  = cyc;
        wr_n++;
      end
      if (!wr) wr_low_n++;
      if (d_oe) doe_n++;
      if (!inta && inta_q && inta_n < 256) begin
        inta_log_c[inta_n] = cyc;
        inta_n++;
      end
      if (!inta && !cs) cs_bad_n++;
      if (!rd && rd_q) rd_n++;
      if (!rd && d_oe) rd_bad_n++;
      if (vec_valid) vv_n++;
      if (cmd_ack) ack_n++;
      wr_q = wr; rd_q = rd; inta_q = inta;
      // First INTA pulse of each acknowledge carries junk; the second the vector.
      if (!rd)        d_in = bus_rdata;
      else if (!inta) d_in = (inta_n % 2 == 1) ? 8'hEE : bus_vec;
      else            d_in = 8'hA5;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    logic done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!busy) begin done = 1'b1; break; end
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic pulse_init(input logic [7:0] w1, w2, w3, w4, o1);
    icw1 = w1; icw2 = w2; icw3 = w3; icw4 = w4; ocw1 = o1;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
  endtask

  // Raise INT, drop it once the first INTA pulse is seen, wait for the vector.
  task automatic run_ack(input string tag);
    int  ib = inta_n;
    int  vb = vv_n;
    logic done = 1'b0;
    int_req = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (inta_n > ib) int_req = 1'b0;
      if (vv_n > vb) begin done = 1'b1; break; end
    end
    int_req = 1'b0;
    check(tag, {31'd0, done}, 32'd1);
  endtask

  int wb, ib, vb, lb, db, rb, ab, cb;

  initial begin
    // Reset values
    repeat (3) tick();
    check("rst_strobes", {28'd0, cs, rd, wr, inta}, 32'hF);
    check("rst_a0_oe", {30'd0, a0, d_oe}, 32'd0);
    check("rst_dout", {24'd0, d_out}, 32'h00);
    check("rst_flags", {29'd0, busy, cmd_ack, vec_valid}, 32'd0);
    check("rst_vec_rdata", {16'd0, vec, cmd_rdata}, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Init, single controller: ICW1=13 -> ICW2, ICW4, OCW1; ICW3 skipped.
    wb = wr_n; lb = wr_low_n; db = doe_n;
    pulse_init(8'h13, 8'h00, 8'hAA, 8'h03, 8'h00);
    wait_idle("init1_done");
    check("init1_count", wr_n - wb, 4);
    check("init1_w0", {23'd0, wr_log_a0[wb],   wr_log_d[wb]},   {23'd0, 1'b0, 8'h13});
    check("init1_w1", {23'd0, wr_log_a0[wb+1], wr_log_d[wb+1]}, {23'd0, 1'b1, 8'h00});
    check("init1_w2", {23'd0, wr_log_a0[wb+2], wr_log_d[wb+2]}, {23'd0, 1'b1, 8'h03});
    check("init1_w3", {23'd0, wr_log_a0[wb+3], wr_log_d[wb+3]}, {23'd0, 1'b1, 8'h00});
    check("init1_wr_low", wr_low_n - lb, 8);
    check("init1_doe", doe_n - db, 16);
    // pulse 2 + hold 1 + gap 1 + setup 1
    check("init1_spacing", wr_log_c[wb+1] - wr_log_c[wb], 5);

    // Init, cascade: ICW1=11 -> ICW2, ICW3, ICW4, OCW1.
    wb = wr_n;
    pulse_init(8'h11, 8'h08, 8'h04, 8'h01, 8'hFB);
    wait_idle("init2_done");
    check("init2_count", wr_n - wb, 5);
    check("init2_w0", {23'd0, wr_log_a0[wb],   wr_log_d[wb]},   {23'd0, 1'b0, 8'h11});
    check("init2_icw3", {23'd0, wr_log_a0[wb+2], wr_log_d[wb+2]}, {23'd0, 1'b1, 8'h04});
    check("init2_ocw1", {23'd0, wr_log_a0[wb+4], wr_log_d[wb+4]}, {23'd0, 1'b1, 8'hFB});

    // Acknowledge without EOI.
    auto_eoi = 1'b0; bus_vec = 8'h05;
    wb = wr_n; ib = inta_n; vb = vv_n; cb = cs_bad_n;
    run_ack("ack1_vv");
    check("ack1_vec", {24'd0, vec}, 32'h05);
    wait_idle("ack1_done");
    repeat (5) tick();
    check("ack1_vv_count", vv_n - vb, 1);
    check("ack1_inta_count", inta_n - ib, 2);
    check("ack1_inta_gap", inta_log_c[ib+1] - inta_log_c[ib], 5);
    check("ack1_cs_high", cs_bad_n - cb, 0);
    check("ack1_no_wr", wr_n - wb, 0);

    // Acknowledge with automatic EOI.
    auto_eoi = 1'b1; bus_vec = 8'h09;
    wb = wr_n; ib = inta_n;
    run_ack("ack2_vv");
    check("ack2_vec", {24'd0, vec}, 32'h09);
    wait_idle("ack2_done");
    auto_eoi = 1'b0;
    check("ack2_inta_count", inta_n - ib, 2);
    check("ack2_eoi_count", wr_n - wb, 1);
    check("ack2_eoi", {23'd0, wr_log_a0[wb], wr_log_d[wb]}, {23'd0, 1'b0, 8'h20});

    // Read command.
    bus_rdata = 8'h0E; ab = ack_n; rb = rd_n; db = doe_n; lb = rd_bad_n;
    cmd_rd = 1'b1; cmd_a0 = 1'b0; cmd_req = 1'b1;
    begin
      logic done = 1'b0;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (cmd_ack) begin
          done = 1'b1;
          check("rd_rdata", {24'd0, cmd_rdata}, 32'h0E);
          cmd_req = 1'b0;
          break;
        end
      end
      cmd_req = 1'b0;
      check("rd_ack_seen", {31'd0, done}, 32'd1);
    end
    repeat (8) tick();
    check("rd_ack_count", ack_n - ab, 1);
    check("rd_pulses", rd_n - rb, 1);
    check("rd_doe_low", doe_n - db, 0);
    check("rd_bad", rd_bad_n - lb, 0);

    // Write command.
    wb = wr_n; ab = ack_n;
    cmd_rd = 1'b0; cmd_a0 = 1'b1; cmd_data = 8'h5C; cmd_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (cmd_ack) break;
    end
    cmd_req = 1'b0;
    repeat (8) tick();
    check("wrc_ack_count", ack_n - ab, 1);
    check("wrc_count", wr_n - wb, 1);
    check("wrc_word", {23'd0, wr_log_a0[wb], wr_log_d[wb]}, {23'd0, 1'b1, 8'h5C});

    // INIT_START and INT_S together: init first, then acknowledge.
    bus_vec = 8'h33; wb = wr_n; ib = inta_n; vb = vv_n;
    int_req = 1'b1;
    repeat (2) tick();
    icw1 = 8'h13; icw2 = 8'h40; icw3 = 8'h00; icw4 = 8'h01; ocw1 = 8'hFE;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    begin
      logic done = 1'b0;
      for (int i = 0; i < 400; i++) begin
        tick();
        if (inta_n > ib) int_req = 1'b0;
        if (vv_n > vb) begin done = 1'b1; break; end
      end
      int_req = 1'b0;
      check("coll_vv", {31'd0, done}, 32'd1);
    end
    wait_idle("coll_done");
    check("coll_wr_count", wr_n - wb, 4);
    check("coll_inta_count", inta_n - ib, 2);
    check("coll_order", {31'd0, inta_log_c[ib] > wr_log_c[wb+3]}, 32'd1);
    check("coll_vec", {24'd0, vec}, 32'h33);

    // Reset during W_PULSE.
    wb = wr_n;
    cmd_rd = 1'b0; cmd_a0 = 1'b0; cmd_data = 8'h77; cmd_req = 1'b1;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        tick();
        if (!wr) begin seen = 1'b1; break; end
      end
      check("rstp_wr_low_seen", {31'd0, seen}, 32'd1);
    end
    rst_n = 1'b0; cmd_req = 1'b0;
    tick();
    check("rstp_wr", {31'd0, wr}, 32'd1);
    check("rstp_busy", {31'd0, busy}, 32'd0);
    check("rstp_cs_oe", {30'd0, cs, d_oe}, 32'b10);
    rst_n = 1'b1;
    repeat (6) tick();
    check("rstp_no_more_wr", wr_n - wb, 1);
    check("rstp_idle", {30'd0, busy, cmd_ack}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/pic_host_bus_master.md
# pic_host_bus_master

Synchronous CPU-side bus master for the programmable interrupt controller; it drives the controller's RD/WR/A0/CS/INTA pins and the shared data bus. It sends the ICW/OCW initialisation sequence, runs host command reads and writes, and answers INT with the two-pulse INTA acknowledge. It samples the vector on the second pulse and can issue an automatic non-specific EOI. It sits between the processor model or fabric and one controller, or the master of a cascade.

## Interface
- SETUP_CYC, 1: cycles the address and data are valid before a WR, RD or INTA strobe falls.
- PULSE_CYC, 2: strobe low width, in cycles.
- HOLD_CYC, 1: cycles the address and data are held after the strobe rises.
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  synchronous, active-low reset.
- INIT_START  in  1  one-cycle pulse that starts the initialisation sequence.
- ICW1, ICW2, ICW3, ICW4, OCW1  in  8 each  initialisation words; sampled when INIT_START is accepted.
- AUTO_EOI  in  1  when 1, write OCW2 = 8'h20 (A0 = 0) after each acknowledge.
- CMD_REQ  in  1  command request; held until CMD_ACK.
- CMD_RD  in  1  1 = read, 0 = write.
- CMD_A0  in  1  A0 value for the command.
- CMD_DATA  in  8  write data.
- CMD_ACK  out  1  one-cycle pulse when the command completes.
- CMD_RDATA  out  8  read data; valid while CMD_ACK is high.
- INT  in  1  interrupt request from the controller; asynchronous.
- VEC_VALID  out  1  one-cycle pulse.
- VEC  out  8  vector captured during the second INTA pulse.
- BUSY  out  1  high in every state except IDLE.
- CS, RD, WR, INTA  out  1 each  active-low strobes.
- A0  out  1  address line.
- D_OUT  out  8  bus data out.
- D_OE  out  1  bus output enable.
- D_IN  in  8  bus data in; the tristate buffer is at the top level.

## Operation
- **Reset values:**
  - CS, RD, WR and INTA = 1.
  - A0 = 0, D_OUT = 8'h00, D_OE = 0.
  - CMD_ACK, VEC_VALID and BUSY = 0; VEC and CMD_RDATA = 8'h00.
  - The FSM goes to IDLE and the INT synchroniser is cleared.
- **INT input:** passes through a 2-flop synchroniser; internal signal INT_S.
- **Arbitration in IDLE**, highest priority first:
  - INIT_START;
  - INT_S = 1;
  - CMD_REQ.
  - An operation that has started always completes.
- **Initialisation:**
  - Queue: ICW1 (A0 = 0), ICW2 (A0 = 1), ICW3 only if ICW1[1] = 0, ICW4 only if ICW1[0] = 1, then OCW1 (A0 = 1).
  - One write cycle per word.
- **Write cycle** (states W_SETUP, W_PULSE, W_HOLD):
  - CS = 0, A0, D_OUT and D_OE = 1 are asserted for the whole cycle.
  - WR = 0 only in W_PULSE.
- **Read cycle** (states R_SETUP, R_PULSE, R_HOLD):
  - CS = 0, D_OE = 0; RD = 0 in R_PULSE.
  - D_IN is captured into CMD_RDATA on the last cycle of R_PULSE.
- **Acknowledge** (states A1_SETUP, A1_PULSE, A1_HOLD, A2_SETUP, A2_PULSE, A2_HOLD):
  - CS = 1 and D_OE = 0 throughout.
  - INTA = 0 in each PULSE state.
  - D_IN is captured into VEC on the last cycle of A2_PULSE.
  - VEC_VALID fires on the cycle after A2_HOLD.
  - Then, if AUTO_EOI was sampled as 1 at the acknowledge start, one EOI write cycle runs; otherwise the FSM returns to IDLE.
- **Data width:** all data is 8 bits; nothing is widened or truncated.

## Timing
- **Phase counter:** each phase lasts exactly its parameter count. The counter reloads at phase entry and a phase ends at count = 0. Zero-valued parameters are illegal; minimum 1.
- **Latency:** an INT rising edge reaches INT_S 2 cycles later. If the FSM is IDLE, A1_SETUP is entered on the next cycle.
- **Bus turnaround:** at least one cycle with all strobes high separates consecutive bus cycles. This is the IDLE or GAP cycle between queue entries.
- **Command handshake:** CMD_ACK fires on the cycle after the HOLD phase. CMD_REQ must drop on that same cycle or a second command is taken.
- **Simultaneous INIT_START and INT_S:** init wins. INT is re-evaluated once init finishes, so a still-high INT is then acknowledged.
- **INT drop:** if INT drops mid-acknowledge, the sequence still completes and returns whatever the bus carries.
- **RST_N low mid-cycle:** every output returns to its reset value on the next edge, including a strobe that was low mid-pulse. Queued init words are discarded.

## Structure
- **Shared package pic_bus_pkg:**
  - the state enum;
  - EOI_NONSPEC = 8'h20;
  - the ICW1 bit positions IC4 = 0 and SNGL = 1.
- **Sub-module pic_bus_cycle:** runs a single SETUP/PULSE/HOLD strobe cycle, given a type (WR, RD or INTA), an A0 value and data. It returns done and the captured data. The top FSM only sequences these cycles.

## Test plan
- **Init, single controller:** parameters 1/2/1, INIT_START with ICW1 = 8'h13, ICW2 = 8'h00, ICW4 = 8'h03, OCW1 = 8'h00.
  - Expect four WR pulses with A0 = 0, 1, 1, 1 and data 13/00/03/00, and no ICW3.
  - Each pulse is 2 cycles wide, with D_OE high 4 cycles per write.
- **Init, cascade:** ICW1 = 8'h11, ICW3 = 8'h04.
  - Expect five writes; the third carries 8'h04 with A0 = 1.
- **Acknowledge:** raise INT, bus model returns 8'h05 on the second INTA.
  - Expect VEC = 8'h05 and one VEC_VALID pulse.
  - Expect two INTA pulses separated by ≥1 all-high cycle, and CS high throughout.
- **Acknowledge with AUTO_EOI = 1:** same as above.
  - Expect a following write with A0 = 0 and D_OUT = 8'h20.
- **Read command:** CMD_RD = 1, CMD_A0 = 0, bus returns 8'h0E.
  - Expect CMD_RDATA = 8'h0E on the CMD_ACK cycle, and D_OE low throughout.
- **Collisions and reset:**
  - INIT_START and INT on the same cycle: the init writes complete first, then the acknowledge.
  - RST_N low during W_PULSE: WR = 1 and BUSY = 0 on the next edge.
